spi_bus_scheduler: RTL and testbench

SPI_BUS_SCHEDULER -- requirements
Module: spi_bus_scheduler

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_rr_arbiter.sv | 43 ++++
 rtl/spi_bus_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_bus_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI bus scheduler:
//   - state_e      : scheduler FSM state encoding (IDLE, SETUP, XFER, GAP)
//   - MODE0..MODE3 : SPI mode constants, encoded as {CPOL,CPHA}
//   - ssw()        : index width for a count of items (clog2, minimum 1 bit)
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Width needed to index n items. Never returns 0, so a single item
   // still gets a one-bit field.
   function automatic int ssw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational round-robin requester selection. The search starts at
// requester 'ptr' and wraps, so the highest priority belongs to the requester
// after the one granted last (the caller advances ptr on each grant).
//
// Ports:
//   req    in  NUM_REQ  request levels
//   ptr    in  IW       first requester to consider
//   grant  out NUM_REQ  one-hot grant (all zero when no request)
//   idx    out IW       index of the granted requester (0 when no request)
// -----------------------------------------------------------------------------
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = ssw(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx
);

   logic found;
   int   pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/spi_bus_scheduler.sv
// -----------------------------------------------------------------------------
// spi_bus_scheduler
// Shares one SPI master engine between NUM_REQ requesters. A requester is
// picked round-robin, its slave select is driven low, and after SETUP_CYCLES
// the engine is started. The received word comes back to that requester with
// a one-cycle Ack, and all selects then stay high for GAP_CYCLES before the
// next grant.
//
// Optional feature: define SPI_SCHED_TIMEOUT_EN to add an XFER watchdog
// (parameter TIMEOUT_CYCLES). When it expires the transaction completes with
// RspErr=1 and RspData=0.
//
// Ports:
//   Clk, Rst         clock; synchronous active-high reset
//   Req              per-requester request level
//   ReqMode          per-requester {CPOL,CPHA}, 2 bits each
//   ReqSel           per-requester slave index, SSW bits each
//   ReqTxData        per-requester transmit word
//   Ack              one-cycle completion pulse to the served requester
//   RspData, RspErr  response word and error flag, valid with Ack
//   MStart           one-cycle start pulse to the engine
//   MMode, MTxData   engine mode and word, held from MStart until MDone
//   MDone, MRxData   engine completion pulse and received word
//   SS_n             active-low slave selects, at most one low
//   StateDbg         current FSM state (state_e encoding) for observation
//
// Engine handshake: MStart is a single-cycle request, with no ready signal.
// The engine owns the bus until it returns a single-cycle MDone. MMode and
// MTxData do not change in between. MDone is honoured only in XFER.
// -----------------------------------------------------------------------------
module spi_bus_scheduler
   import spi_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int DATA_WIDTH     = 8,
   parameter  int NUM_SS         = 4,
   parameter  int SETUP_CYCLES   = 2,
   parameter  int GAP_CYCLES     = 3
`ifdef SPI_SCHED_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1024
`endif
   ,localparam int SSW           = ssw(NUM_SS)
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [NUM_REQ-1:0]             Req,
   input  logic [2*NUM_REQ-1:0]           ReqMode,
   input  logic [SSW*NUM_REQ-1:0]         ReqSel,
   input  logic [DATA_WIDTH*NUM_REQ-1:0]  ReqTxData,
   output logic [NUM_REQ-1:0]             Ack,
   output logic [DATA_WIDTH-1:0]          RspData,
   output logic                           RspErr,
   output logic                           MStart,
   output logic [1:0]                     MMode,
   output logic [DATA_WIDTH-1:0]          MTxData,
   input  logic                           MDone,
   input  logic [DATA_WIDTH-1:0]          MRxData,
   output logic [NUM_SS-1:0]              SS_n,
   output logic [1:0]                     StateDbg
);

   localparam int IW = ssw(NUM_REQ);
   localparam int CW = 16;

   // ---------------------------------------------------------------- state
   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic                    sel_err_q, sel_err_d;
   logic [NUM_SS-1:0]       ss_n_q, ss_n_d;
   logic                    mstart_q, mstart_d;
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [1:0]              mmode_q, mmode_d;
   logic [DATA_WIDTH-1:0]   mtx_q, mtx_d;

`ifdef SPI_SCHED_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [WW-1:0]           wd_q, wd_d;
`endif

   // ---------------------------------------------------------- arbitration
   logic [NUM_REQ-1:0]      arb_grant;
   logic [IW-1:0]           arb_idx;
   logic                    any_req;
   logic [SSW-1:0]          cand_sel;
   logic [NUM_SS-1:0]       cand_ss;
   logic                    cand_sel_ok;
   logic [IW-1:0]           ptr_next;

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req   (Req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   assign any_req  = |Req;
   assign ptr_next = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);

   // Decode the candidate's slave index. A value with no matching line
   // (>= NUM_SS) leaves cand_ss all zero, which marks the request as an error.
   always_comb begin
      cand_sel = ReqSel[SSW*int'(arb_idx) +: SSW];
      cand_ss  = '0;
      for (int s = 0; s < NUM_SS; s++) begin
         cand_ss[s] = (cand_sel == SSW'(s));
      end
      cand_sel_ok = |cand_ss;
   end

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      sel_err_d  = sel_err_q;
      ss_n_d     = ss_n_q;
      mstart_d   = 1'b0;
      ack_d      = '0;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = 1'b0;
      mmode_d    = mmode_q;
      mtx_d      = mtx_q;
`ifdef SPI_SCHED_TIMEOUT_EN
      wd_d       = wd_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               // Everything about the transaction is captured here, so later
               // Req/ReqMode/ReqSel/ReqTxData changes cannot disturb it.
               gnt_d     = arb_grant;
               ptr_d     = ptr_next;
               mmode_d   = ReqMode[2*int'(arb_idx) +: 2];
               mtx_d     = ReqTxData[DATA_WIDTH*int'(arb_idx) +: DATA_WIDTH];
               sel_err_d = ~cand_sel_ok;
               ss_n_d    = cand_sel_ok ? ~cand_ss : '1;
               cnt_d     = '0;
               state_d   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
               cnt_d = '0;
               if (sel_err_q) begin
                  // Bad slave index: no select was driven, the engine is
                  // never started, and the requester gets an error response.
                  ack_d      = gnt_q;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
                  ss_n_d     = '1;
                  state_d    = ST_GAP;
               end else begin
                  mstart_d = 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
                  wd_d     = '0;
`endif
                  state_d  = ST_XFER;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_XFER: begin
            if (MDone) begin
               ack_d      = gnt_q;
               rsp_data_d = MRxData;
               rsp_err_d  = 1'b0;
               ss_n_d     = '1;
               cnt_d      = '0;
               state_d    = ST_GAP;
            end
`ifdef SPI_SCHED_TIMEOUT_EN
            else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
               ack_d      = gnt_q;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               ss_n_d     = '1;
               cnt_d      = '0;
               state_d    = ST_GAP;
            end else begin
               wd_d = wd_q + WW'(1);
            end
`endif
         end

         ST_GAP: begin
            ss_n_d = '1;
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            ss_n_d  = '1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ registers
   // Reset drops every select and clears the pending grant, so a transaction
   // in progress ends without an Ack.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         gnt_q      <= '0;
         sel_err_q  <= 1'b0;
         ss_n_q     <= '1;
         mstart_q   <= 1'b0;
         ack_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         mmode_q    <= MODE0;
         mtx_q      <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
         wd_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         sel_err_q  <= sel_err_d;
         ss_n_q     <= ss_n_d;
         mstart_q   <= mstart_d;
         ack_q      <= ack_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         mmode_q    <= mmode_d;
         mtx_q      <= mtx_d;
`ifdef SPI_SCHED_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   assign Ack      = ack_q;
   assign RspData  = rsp_data_q;
   assign RspErr   = rsp_err_q;
   assign MStart   = mstart_q;
   assign MMode    = mmode_q;
   assign MTxData  = mtx_q;
   assign SS_n     = ss_n_q;
   assign StateDbg = state_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_scheduler
// Directed bench for spi_bus_scheduler. u_dut uses the default parameters.
// u_dut_err uses NUM_SS=5, which gives a 3-bit ReqSel field, so the select
// value 5 can be driven as an out-of-range slave index.
// Inputs change #1 after the rising edge, and outputs are sampled at the same
// point.
// -----------------------------------------------------------------------------
module tb_spi_bus_scheduler;
   import spi_pkg::*;

   // ------------------------------------------------------ clock / reset
   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   // ------------------------------------------------------------- signals
   logic [3:0]  Req, Req2;
   logic [7:0]  ReqMode;
   logic [7:0]  ReqSel;
   logic [11:0] ReqSel2;
   logic [31:0] ReqTxData;
   logic        MDone;
   logic [7:0]  MRxData;

   logic [3:0]  Ack, Ack2;
   logic [7:0]  RspData, RspData2;
   logic        RspErr, RspErr2;
   logic        MStart, MStart2;
   logic [1:0]  MMode, MMode2;
   logic [7:0]  MTxData, MTxData2;
   logic [3:0]  SS_n;
   logic [4:0]  SS_n2;
   logic [1:0]  StateDbg, StateDbg2;

   int tests_run    = 0;
   int tests_failed = 0;

   spi_bus_scheduler u_dut (
      .Clk(Clk), .Rst(Rst), .Req(Req), .ReqMode(ReqMode), .ReqSel(ReqSel),
      .ReqTxData(ReqTxData), .Ack(Ack), .RspData(RspData), .RspErr(RspErr),
      .MStart(MStart), .MMode(MMode), .MTxData(MTxData), .MDone(MDone),
      .MRxData(MRxData), .SS_n(SS_n), .StateDbg(StateDbg)
   );

   spi_bus_scheduler #(.NUM_SS(5)) u_dut_err (
      .Clk(Clk), .Rst(Rst), .Req(Req2), .ReqMode(ReqMode), .ReqSel(ReqSel2),
      .ReqTxData(ReqTxData), .Ack(Ack2), .RspData(RspData2), .RspErr(RspErr2),
      .MStart(MStart2), .MMode(MMode2), .MTxData(MTxData2), .MDone(MDone),
      .MRxData(MRxData), .SS_n(SS_n2), .StateDbg(StateDbg2)
   );

   // ------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on u_dut. Call it while the DUT is in IDLE with
   // the request already driven. The engine answers one cycle after MStart.
   task automatic serve(input string tag, input int idx, input logic [3:0] ss,
                        input logic [7:0] tx, input logic [1:0] mode,
                        input logic [7:0] rx, input logic [3:0] req_after);
      logic [3:0] exp_ack;
      exp_ack = 4'(1 << idx);
      tick();                                    // grant edge
      chk({tag, " ss_setup"}, SS_n, ss);
      chk({tag, " st_setup"}, StateDbg, ST_SETUP);
      chk({tag, " mstart_early0"}, MStart, 1'b0);
      Req = req_after;
      tick();
      chk({tag, " mstart_early1"}, MStart, 1'b0);
      tick();                                    // two cycles after SS_n fell
      chk({tag, " mstart"}, MStart, 1'b1);
      chk({tag, " mtx"}, MTxData, tx);
      chk({tag, " mmode_start"}, MMode, mode);
      chk({tag, " ss_xfer"}, SS_n, ss);
      tick();
      chk({tag, " mstart_pulse"}, MStart, 1'b0);
      chk({tag, " st_xfer"}, StateDbg, ST_XFER);
      MDone   = 1'b1;
      MRxData = rx;
      tick();
      MDone   = 1'b0;
      MRxData = 8'h00;
      chk({tag, " ack"}, Ack, exp_ack);
      chk({tag, " rsp_data"}, RspData, rx);
      chk({tag, " rsp_err"}, RspErr, 1'b0);
      chk({tag, " mmode_done"}, MMode, mode);
      chk({tag, " ss_gap1"}, SS_n, 4'hF);
      tick();
      chk({tag, " ack_pulse"}, Ack, 4'h0);
      chk({tag, " ss_gap2"}, SS_n, 4'hF);
      tick();
      chk({tag, " ss_gap3"}, SS_n, 4'hF);
      chk({tag, " st_gap3"}, StateDbg, ST_GAP);
      tick();
      chk({tag, " st_idle"}, StateDbg, ST_IDLE);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      Rst = 1'b1; Req = '0; Req2 = '0; ReqMode = '0; ReqSel = '0; ReqSel2 = '0;
      ReqTxData = '0; MDone = 1'b0; MRxData = '0;
      tick();
      tick();
      chk("rst ss_n", SS_n, 4'hF);
      chk("rst ack", Ack, 4'h0);
      chk("rst mstart", MStart, 1'b0);
      chk("rst rsp_err", RspErr, 1'b0);
      chk("rst rsp_data", RspData, 8'h00);
      chk("rst mmode", MMode, 2'b00);
      chk("rst mtx", MTxData, 8'h00);
      chk("rst state", StateDbg, ST_IDLE);
      chk("rst ss_n2", SS_n2, 5'h1F);
      Rst = 1'b0;

      // Single request. Req is dropped right after the grant, and the
      // requester is still acknowledged.
      Req = 4'b0001; ReqSel = 8'h02; ReqTxData = 32'h0000_00A5; ReqMode = {4{MODE0}};
      serve("single", 0, 4'b1011, 8'hA5, MODE0, 8'h3C, 4'b0000);

      // MDone while IDLE is ignored.
      MDone = 1'b1; MRxData = 8'h77;
      tick();
      MDone = 1'b0;
      chk("idle_mdone ack", Ack, 4'h0);
      chk("idle_mdone state", StateDbg, ST_IDLE);
      chk("idle_mdone rsp_data", RspData, 8'h3C);

      // All requesters held high: grant order 0,1,2,3,0, starting after reset.
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      ReqSel    = 8'b11_10_01_00;
      ReqTxData = 32'h4433_2211;
      ReqMode   = {MODE2, MODE1, MODE3, MODE0};
      Req       = 4'hF;
      serve("rr0", 0, 4'b1110, 8'h11, MODE0, 8'h80, 4'hF);
      serve("rr1", 1, 4'b1101, 8'h22, MODE3, 8'h81, 4'hF);
      serve("rr2", 2, 4'b1011, 8'h33, MODE1, 8'h82, 4'hF);
      serve("rr3", 3, 4'b0111, 8'h44, MODE2, 8'h83, 4'hF);
      serve("rr0b", 0, 4'b1110, 8'h11, MODE0, 8'h84, 4'h0);

      // Reset during XFER aborts the transaction. Requester 2 is the only one
      // requesting.
      Req = 4'b0100;
      tick();
      chk("abort ss_setup", SS_n, 4'b1011);
      Req = 4'b0000;
      tick();
      tick();
      chk("abort mstart", MStart, 1'b1);
      tick();
      chk("abort st_xfer", StateDbg, ST_XFER);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("abort ss_n", SS_n, 4'hF);
      chk("abort state", StateDbg, ST_IDLE);
      chk("abort ack", Ack, 4'h0);
      MDone = 1'b1; MRxData = 8'hEE;
      tick();
      MDone = 1'b0;
      chk("abort late_mdone ack", Ack, 4'h0);
      chk("abort late_mdone state", StateDbg, ST_IDLE);

      // Five-slave instance: a valid select on line 4 first.
      Req2 = 4'b0001; ReqSel2 = 12'h004;
      tick();
      chk("ss5 ss_n", SS_n2, 5'b01111);
      Req2 = 4'b0000;
      tick();
      tick();
      chk("ss5 mstart", MStart2, 1'b1);
      tick();
      MDone = 1'b1; MRxData = 8'h5A;
      tick();
      MDone = 1'b0;
      chk("ss5 ack", Ack2, 4'b0001);
      chk("ss5 rsp_data", RspData2, 8'h5A);
      chk("ss5 main_unaffected", Ack, 4'h0);
      tick();
      tick();
      tick();
      chk("ss5 st_idle", StateDbg2, ST_IDLE);

      // Out-of-range select (5) from requester 1: error response, no selects,
      // and no engine start.
      Req2 = 4'b0010; ReqSel2 = 12'h028;
      tick();
      chk("badsel ss_n0", SS_n2, 5'h1F);
      chk("badsel mstart0", MStart2, 1'b0);
      chk("badsel st_setup", StateDbg2, ST_SETUP);
      tick();
      chk("badsel ss_n1", SS_n2, 5'h1F);
      chk("badsel mstart1", MStart2, 1'b0);
      chk("badsel ack_early", Ack2, 4'h0);
      tick();
      chk("badsel ack", Ack2, 4'b0010);
      chk("badsel rsp_err", RspErr2, 1'b1);
      chk("badsel rsp_data", RspData2, 8'h00);
      chk("badsel mstart2", MStart2, 1'b0);
      chk("badsel ss_n2", SS_n2, 5'h1F);
      Req2 = 4'b0000;
      tick();
      chk("badsel ack_pulse", Ack2, 4'h0);
      chk("badsel rsp_err_pulse", RspErr2, 1'b0);
      chk("badsel st_gap", StateDbg2, ST_GAP);

`ifdef SPI_SCHED_TIMEOUT_EN
      // The engine never answers, so the watchdog fires after 1024 XFER cycles.
      Req = 4'b0001;
      tick();
      Req = 4'b0000;
      tick();
      tick();
      chk("wd mstart", MStart, 1'b1);
      for (int i = 0; i < 1023; i++) tick();
      chk("wd ack_before", Ack, 4'h0);
      chk("wd st_xfer", StateDbg, ST_XFER);
      tick();
      chk("wd ack", Ack, 4'b0001);
      chk("wd rsp_err", RspErr, 1'b1);
      chk("wd rsp_data", RspData, 8'h00);
      chk("wd ss_n", SS_n, 4'hF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
